// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Generates N_CHANNELS staggered, active-low resets from a single clock once
// the PLL/MMCM lock indication has been synchronised and filtered. After lock
// qualifies, every output is held low for HOLD_CYCLES. The outputs are then
// released in order, bit 0 first, one every STAGGER_CYCLES. Loss of lock or a
// software request aborts the sequence and starts it again from WAIT_LOCK.
// Each abort taken outside WAIT_LOCK is counted in a saturating counter.
//
// Ports
//   sys_clk        sequencer clock
//   sys_reset_n    asynchronous active-low reset (deassertion already synchronous)
//   locked_in      PLL/MMCM lock, asynchronous to sys_clk
//   sw_rst_req     single-cycle software re-sequence request (sys_clk domain)
//   rst_n_out      per-channel active-low resets, bit 0 released first
//   seq_done       high while every channel is released
//   seq_state      registered state: 0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 DONE
//   restart_count  aborted/restarted sequences, saturates at 255
//
// Every output comes straight from a flop. No input reaches an output
// through combinational logic.
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int N_CHANNELS     = 4,    // 1..16
  parameter int HOLD_CYCLES    = 200,  // >= 1
  parameter int STAGGER_CYCLES = 16,   // 0 releases all channels together
  parameter int LOCK_FILTER    = 8,    // >= 1
  parameter int CNT_WIDTH      = 16    // must hold the largest of the three counts
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  locked_in,
  input  logic                  sw_rst_req,
  output logic [N_CHANNELS-1:0] rst_n_out,
  output logic                  seq_done,
  output logic [1:0]            seq_state,
  output logic [7:0]            restart_count
);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam int IDX_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  // A single channel, or zero stagger, releases every output at the end of
  // HOLD and skips RELEASE entirely.
  localparam bit RELEASE_ALL = (N_CHANNELS == 1) || (STAGGER_CYCLES == 0);

  localparam logic [CNT_WIDTH-1:0] LOCK_TGT    = CNT_WIDTH'(LOCK_FILTER);
  localparam logic [CNT_WIDTH-1:0] HOLD_TGT    = CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] STAGGER_TGT = CNT_WIDTH'(STAGGER_CYCLES);
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_CHANNELS - 1);
  localparam logic [7:0]           RC_MAX      = 8'd255;

  // Two-flop synchroniser for the asynchronous lock input.
  logic lock_meta;
  logic locked_s;

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]    cnt_inc;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N_CHANNELS-1:0]   rst_q, rst_d;
  logic                    done_q, done_d;
  logic [7:0]              restart_q, restart_d;
  logic                    abort;

  assign cnt_inc = cnt_q + CNT_WIDTH'(1);

  // Abort applies to any state that has already left WAIT_LOCK. Lock loss and
  // a software request on the same edge are one event and count once.
  assign abort = (state_q != ST_WAIT_LOCK) && (!locked_s || sw_rst_req);

  // NOTE: every flop is reset, the synchroniser included. The reset releases
  // in a known state and a stale lock cannot survive a reset.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_q     <= '0;
      done_q    <= 1'b0;
      restart_q <= '0;
    end else begin
      // NOTE: state flops use non-blocking assignments. Every flop then
      // samples pre-edge values regardless of statement order.
      lock_meta <= locked_in;
      locked_s  <= lock_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_q     <= rst_d;
      done_q    <= done_d;
      restart_q <= restart_d;
    end
  end

  always_comb begin
    // NOTE: each next-state signal starts out holding its current value. No
    // path through the case can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    done_d    = done_q;
    restart_d = restart_q;

    if (abort) begin
      // An abort overrides any release due on the same edge.
      state_d = ST_WAIT_LOCK;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
      if (restart_q != RC_MAX) begin
        restart_d = restart_q + 8'd1;
      end
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          // Lock must be seen high on LOCK_FILTER consecutive edges. Any low
          // sample or software request restarts the qualification.
          if (!locked_s || sw_rst_req) begin
            cnt_d = '0;
          end else if (cnt_inc == LOCK_TGT) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_HOLD: begin
          if (cnt_inc == HOLD_TGT) begin
            cnt_d = '0;
            if (RELEASE_ALL) begin
              rst_d   = '1;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              rst_d[0] = 1'b1;
              idx_d    = IDX_W'(1);
              state_d  = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_RELEASE: begin
          // idx_q is the next channel to release, and is always in range here.
          if (cnt_inc == STAGGER_TGT) begin
            cnt_d        = '0;
            rst_d[idx_q] = 1'b1;
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end

        ST_DONE: begin
          // Hold the released state until an abort.
        end

        default: begin
          state_d = ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign rst_n_out     = rst_q;
  assign seq_done      = done_q;
  assign seq_state     = state_q;
  assign restart_count = restart_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Scoreboarded bench for reset_sequencer. Three builds are instantiated:
//   dut     N=4, STAGGER=16  (main sequence, aborts, saturation)
//   dut_s0  N=4, STAGGER=0   (all channels released together)
//   dut_n1  N=1, STAGGER=16  (single channel)
// Only one build is out of reset at a time.
//
// The stimulus process pushes each output change it expects into sb_q. Each
// entry holds the build, the edge number after reset release, and the packed
// output value. A monitor samples every build on the falling edge. Whenever
// an active build's outputs change, the monitor pops one entry and compares
// the build, the edge and the value.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  logic sys_clk     = 1'b0;
  logic rst_main    = 1'b0;
  logic rst_s0      = 1'b0;
  logic rst_n1      = 1'b0;
  logic locked_in   = 1'b0;
  logic sw_rst_req  = 1'b0;

  logic [3:0] m_rst;  logic m_done;  logic [1:0] m_st;  logic [7:0] m_rc;
  logic [3:0] s0_rst; logic s0_done; logic [1:0] s0_st; logic [7:0] s0_rc;
  logic [0:0] n1_rst; logic n1_done; logic [1:0] n1_st; logic [7:0] n1_rc;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;   // free-running rising-edge count
  int t0       = 0;   // ecnt at the most recent reset release

  typedef struct {
    int          dut;
    int          edge_n;
    logic [14:0] obs;   // {rst_n_out(4), seq_done, seq_state(2), restart_count(8)}
  } exp_t;

  exp_t        sb_q[$];
  logic [14:0] prev [3];
  logic [14:0] mon_cur;
  exp_t        mon_e;
  int          mon_edge;

  reset_sequencer #(
    .N_CHANNELS(4), .HOLD_CYCLES(200), .STAGGER_CYCLES(16), .LOCK_FILTER(8), .CNT_WIDTH(16)
  ) dut (
    .sys_clk(sys_clk), .sys_reset_n(rst_main), .locked_in(locked_in), .sw_rst_req(sw_rst_req),
    .rst_n_out(m_rst), .seq_done(m_done), .seq_state(m_st), .restart_count(m_rc)
  );

  reset_sequencer #(
    .N_CHANNELS(4), .HOLD_CYCLES(200), .STAGGER_CYCLES(0), .LOCK_FILTER(8), .CNT_WIDTH(16)
  ) dut_s0 (
    .sys_clk(sys_clk), .sys_reset_n(rst_s0), .locked_in(locked_in), .sw_rst_req(sw_rst_req),
    .rst_n_out(s0_rst), .seq_done(s0_done), .seq_state(s0_st), .restart_count(s0_rc)
  );

  reset_sequencer #(
    .N_CHANNELS(1), .HOLD_CYCLES(200), .STAGGER_CYCLES(16), .LOCK_FILTER(8), .CNT_WIDTH(16)
  ) dut_n1 (
    .sys_clk(sys_clk), .sys_reset_n(rst_n1), .locked_in(locked_in), .sw_rst_req(sw_rst_req),
    .rst_n_out(n1_rst), .seq_done(n1_done), .seq_state(n1_st), .restart_count(n1_rc)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) ecnt <= ecnt + 1;

  function automatic logic [14:0] pack_obs(input logic [3:0] r, input logic d,
                                           input logic [1:0] s, input logic [7:0] c);
    return {r, d, s, c};
  endfunction

  function automatic logic [14:0] observe(input int d);
    case (d)
      0:       return {m_rst, m_done, m_st, m_rc};
      1:       return {s0_rst, s0_done, s0_st, s0_rc};
      default: return {3'b000, n1_rst, n1_done, n1_st, n1_rc};
    endcase
  endfunction

  function automatic logic dut_active(input int d);
    case (d)
      0:       return rst_main;
      1:       return rst_s0;
      default: return rst_n1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int d, input int e, input logic [3:0] r, input logic dn,
                           input logic [1:0] s, input logic [7:0] c);
    exp_t x;
    x.dut    = d;
    x.edge_n = e;
    x.obs    = pack_obs(r, dn, s, c);
    sb_q.push_back(x);
  endtask

  // Returns at the falling edge that follows rising edge e (edges counted
  // from reset release). Inputs driven here are first sampled on edge e+1.
  task automatic wait_edge(input int e);
    while ((ecnt - t0) < e) @(negedge sys_clk);
  endtask

  // Holds all builds in reset, checks the reset state of build d, then
  // releases build d on a falling edge.
  task automatic start_dut(input int d, input logic lock);
    rst_main   = 1'b0;
    rst_s0     = 1'b0;
    rst_n1     = 1'b0;
    sw_rst_req = 1'b0;
    locked_in  = lock;
    repeat (3) @(negedge sys_clk);
    check("reset_state", 32'(observe(d)), 32'(pack_obs(4'b0000, 1'b0, 2'd0, 8'd0)));
    case (d)
      0:       rst_main = 1'b1;
      1:       rst_s0   = 1'b1;
      default: rst_n1   = 1'b1;
    endcase
    t0 = ecnt;
  endtask

  task automatic expect_nominal(input int d);
    expect_ev(d, 10,  4'b0000, 1'b0, 2'd1, 8'd0);
    expect_ev(d, 210, 4'b0001, 1'b0, 2'd2, 8'd0);
    expect_ev(d, 226, 4'b0011, 1'b0, 2'd2, 8'd0);
    expect_ev(d, 242, 4'b0111, 1'b0, 2'd2, 8'd0);
    expect_ev(d, 258, 4'b1111, 1'b1, 2'd3, 8'd0);
  endtask

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    for (int d = 0; d < 3; d++) begin
      mon_cur  = observe(d);
      mon_edge = ecnt - t0;
      if (dut_active(d) && (mon_cur !== prev[d])) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected dut=%0d edge=%0d got=%b want=no_change", d, mon_edge, mon_cur);
        end else begin
          mon_e = sb_q.pop_front();
          if ((mon_e.dut != d) || (mon_e.edge_n != mon_edge) || (mon_e.obs !== mon_cur)) begin
            failures++;
            $display("FAIL sb_event got dut=%0d edge=%0d obs=%b want dut=%0d edge=%0d obs=%b",
                     d, mon_edge, mon_cur, mon_e.dut, mon_e.edge_n, mon_e.obs);
          end
        end
      end
      prev[d] = mon_cur;
    end
  end

  initial begin
    int rc;
    int nrc;
    int h;

    // 1. Nominal sequence, then asynchronous reset while in DONE
    start_dut(0, 1'b1);
    expect_nominal(0);
    wait_edge(270);
    #2 rst_main = 1'b0;
    #1;
    check("async_rst_done_rst_n_out", 32'(m_rst), 32'h0);
    check("async_rst_done_seq_done", 32'(m_done), 32'h0);
    check("async_rst_done_seq_state", 32'(m_st), 32'h0);

    // 2. Lock filter: 5 high / 1 low never qualifies
    start_dut(0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      locked_in = 1'b1;
      repeat (5) @(negedge sys_clk);
      locked_in = 1'b0;
      @(negedge sys_clk);
    end
    repeat (4) @(negedge sys_clk);
    check("filter_seq_state", 32'(m_st), 32'h0);
    check("filter_rst_n_out", 32'(m_rst), 32'h0);

    // 3. Lock loss mid-release, then a full sequence after recovery
    start_dut(0, 1'b1);
    expect_ev(0, 10,  4'b0000, 1'b0, 2'd1, 8'd0);
    expect_ev(0, 210, 4'b0001, 1'b0, 2'd2, 8'd0);
    expect_ev(0, 226, 4'b0011, 1'b0, 2'd2, 8'd0);
    expect_ev(0, 229, 4'b0000, 1'b0, 2'd0, 8'd1);
    expect_ev(0, 239, 4'b0000, 1'b0, 2'd1, 8'd1);
    expect_ev(0, 439, 4'b0001, 1'b0, 2'd2, 8'd1);
    expect_ev(0, 455, 4'b0011, 1'b0, 2'd2, 8'd1);
    expect_ev(0, 471, 4'b0111, 1'b0, 2'd2, 8'd1);
    expect_ev(0, 487, 4'b1111, 1'b1, 2'd3, 8'd1);
    wait_edge(226);
    locked_in = 1'b0;
    wait_edge(229);
    locked_in = 1'b1;
    wait_edge(495);

    // 4. Software reset in DONE
    start_dut(0, 1'b1);
    expect_nominal(0);
    expect_ev(0, 271, 4'b0000, 1'b0, 2'd0, 8'd1);
    expect_ev(0, 279, 4'b0000, 1'b0, 2'd1, 8'd1);
    expect_ev(0, 479, 4'b0001, 1'b0, 2'd2, 8'd1);
    wait_edge(270);
    sw_rst_req = 1'b1;
    wait_edge(271);
    sw_rst_req = 1'b0;
    wait_edge(485);

    // 5. Lock loss and software request on the same edge, then saturation
    start_dut(0, 1'b1);
    expect_ev(0, 10, 4'b0000, 1'b0, 2'd1, 8'd0);
    expect_ev(0, 23, 4'b0000, 1'b0, 2'd0, 8'd1);
    wait_edge(20);
    locked_in = 1'b0;            // locked_s first seen low on edge 23
    wait_edge(22);
    sw_rst_req = 1'b1;           // also sampled on edge 23
    wait_edge(23);
    sw_rst_req = 1'b0;
    locked_in  = 1'b1;           // locked_s high after edge 25, HOLD at 33
    rc = 1;
    h  = 33;
    for (int i = 0; i < 299; i++) begin
      nrc = (rc < 255) ? rc + 1 : 255;
      expect_ev(0, h,     4'b0000, 1'b0, 2'd1, 8'(rc));
      expect_ev(0, h + 1, 4'b0000, 1'b0, 2'd0, 8'(nrc));
      wait_edge(h);
      sw_rst_req = 1'b1;
      wait_edge(h + 1);
      sw_rst_req = 1'b0;
      rc = nrc;
      h  = h + 9;
    end
    repeat (3) @(negedge sys_clk);
    check("saturated_restart_count", 32'(m_rc), 32'd255);

    // 6a. STAGGER=0: every channel released together with seq_done
    start_dut(1, 1'b1);
    expect_ev(1, 10,  4'b0000, 1'b0, 2'd1, 8'd0);
    expect_ev(1, 210, 4'b1111, 1'b1, 2'd3, 8'd0);
    wait_edge(215);

    // 6b. Single channel
    start_dut(2, 1'b1);
    expect_ev(2, 10,  4'b0000, 1'b0, 2'd1, 8'd0);
    expect_ev(2, 210, 4'b0001, 1'b1, 2'd3, 8'd0);
    wait_edge(215);

    // 6c. Asynchronous reset in the middle of HOLD
    start_dut(1, 1'b1);
    expect_ev(1, 10, 4'b0000, 1'b0, 2'd1, 8'd0);
    wait_edge(100);
    check("midhold_state_before_rst", 32'(s0_st), 32'd1);
    #2 rst_s0 = 1'b0;
    #1;
    check("midhold_async_seq_state", 32'(s0_st), 32'd0);
    check("midhold_async_rst_n_out", 32'(s0_rst), 32'h0);
    check("midhold_async_seq_done", 32'(s0_done), 32'h0);

    repeat (3) @(negedge sys_clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
